// File: rtl/gray_conv_arbiter.sv
// Round-robin arbiter that shares one registered binary/Gray conversion stage
// between N requesters and returns tagged results on a valid/ready port.
module gray_conv_arbiter #(
  parameter int N   = 4,
  parameter int W   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [N-1:0]     req_mode,
  input  logic [N*W-1:0]   req_data,
  output logic [N-1:0]     req_ready,
  output logic             resp_valid,
  output logic [W-1:0]     resp_data,
  output logic             resp_mode,
  output logic [IDW-1:0]   resp_id,
  input  logic             resp_ready,
  output logic [15:0]      conv_count
);

  localparam logic [IDW-1:0] LAST_RST = IDW'(N - 1);

  function automatic logic [W-1:0] bin2gray(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
    logic [W-1:0] b;
    b = '0;
    b[W-1] = g[W-1];
    for (int k = W - 2; k >= 0; k--) begin
      b[k] = b[k+1] ^ g[k];
    end
    return b;
  endfunction

  logic [IDW-1:0] last_r;
  logic           resp_valid_r;
  logic [W-1:0]   resp_data_r;
  logic           resp_mode_r;
  logic [IDW-1:0] resp_id_r;
  logic [15:0]    conv_count_r;

  logic           slot_free_s;
  logic           grant_found_s;
  logic           grant_en_s;
  logic [IDW-1:0] grant_idx_s;
  logic [W-1:0]   sel_data_s;
  logic           sel_mode_s;
  logic [W-1:0]   conv_data_s;
  logic           drain_s;

  assign slot_free_s = !resp_valid_r || resp_ready;
  assign drain_s     = resp_valid_r && resp_ready;
  assign grant_en_s  = slot_free_s && grant_found_s && !rst;

  // Round-robin search upward from the requester after the last grant.
  always_comb begin
    int idx_v;
    idx_v         = 0;
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    sel_data_s    = '0;
    sel_mode_s    = 1'b0;
    for (int k = 1; k <= N; k++) begin
      idx_v = (int'(last_r) + k) % N;
      if (!grant_found_s && req_valid[idx_v]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = IDW'(idx_v);
        sel_data_s    = req_data[idx_v*W +: W];
        sel_mode_s    = req_mode[idx_v];
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // Conversion of the selected operand and the one-hot accept strobe.
  always_comb begin
    conv_data_s = '0;
    req_ready   = '0;
    if (sel_mode_s) begin
      conv_data_s = gray2bin(sel_data_s);
    end else begin
      conv_data_s = bin2gray(sel_data_s);
    end
    if (grant_en_s) begin
      req_ready = N'(1) << grant_idx_s;
    end else begin
      req_ready = '0;
    end
  end

  // Result register and round-robin pointer; a held result stays frozen under backpressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r       <= LAST_RST;
      resp_valid_r <= 1'b0;
      resp_data_r  <= '0;
      resp_mode_r  <= 1'b0;
      resp_id_r    <= '0;
    end else if (grant_en_s) begin
      last_r       <= grant_idx_s;
      resp_valid_r <= 1'b1;
      resp_data_r  <= conv_data_s;
      resp_mode_r  <= sel_mode_s;
      resp_id_r    <= grant_idx_s;
    end else if (drain_s) begin
      resp_valid_r <= 1'b0;
    end
  end

  // Saturating count of completed response handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      conv_count_r <= 16'd0;
    end else if (drain_s && (conv_count_r != 16'hFFFF)) begin
      conv_count_r <= conv_count_r + 16'd1;
    end
  end

  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;
  assign resp_mode  = resp_mode_r;
  assign resp_id    = resp_id_r;
  assign conv_count = conv_count_r;

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed self-checking bench for gray_conv_arbiter (N=4, W=4) with
// hand-computed expected conversions, grant orders and counter values.
module tb_gray_conv_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_mode;
  logic [15:0] req_data;
  logic [3:0]  req_ready;
  logic        resp_valid;
  logic [3:0]  resp_data;
  logic        resp_mode;
  logic [1:0]  resp_id;
  logic        resp_ready;
  logic [15:0] conv_count;

  int errors = 0;
  int checks = 0;

  gray_conv_arbiter #(.N(4), .W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_mode(req_mode), .req_data(req_data),
    .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_mode(resp_mode),
    .resp_id(resp_id), .resp_ready(resp_ready), .conv_count(conv_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b1111; req_mode = 4'b0000; req_data = 16'h0000; resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", req_ready); end
    step();
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready2: got %b want 0000", req_ready); end
    rst = 1'b0; req_valid = 4'b0000;
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", resp_valid); end
    checks++; if (resp_data !== 4'h0) begin errors++; $display("FAIL reset_data: got %h want 0", resp_data); end
    checks++; if (resp_mode !== 1'b0 || resp_id !== 2'd0) begin errors++; $display("FAIL reset_mode_id: got %b/%0d want 0/0", resp_mode, resp_id); end
    checks++; if (conv_count !== 16'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", conv_count); end
  endtask

  task automatic test_single();
    req_valid = 4'b0001; req_mode = 4'b0000; req_data = 16'h000B; resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
    step();
    req_valid = 4'b0000;
    checks++; if (resp_valid !== 1'b1 || resp_data !== 4'b1110 || resp_id !== 2'd0 || resp_mode !== 1'b0)
      begin errors++; $display("FAIL single_resp: got v=%b d=%b id=%0d m=%b want 1/1110/0/0", resp_valid, resp_data, resp_id, resp_mode); end
    step();
    checks++; if (conv_count !== 16'd1 || resp_valid !== 1'b0) begin errors++; $display("FAIL single_count: got %0d v=%b want 1 v=0", conv_count, resp_valid); end
  endtask

  task automatic test_roundtrip();
    req_valid = 4'b0100; req_mode = 4'b0100; req_data = 16'h0E00;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rt_ready: got %b want 0100", req_ready); end
    step();
    checks++; if (resp_data !== 4'b1011 || resp_id !== 2'd2 || resp_mode !== 1'b1)
      begin errors++; $display("FAIL rt_g2b: got d=%b id=%0d m=%b want 1011/2/1", resp_data, resp_id, resp_mode); end
    req_mode = 4'b0000; req_data = 16'h0500;
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rt_ready2: got %b want 0100", req_ready); end
    step();
    req_valid = 4'b0000;
    checks++; if (resp_data !== 4'b0111 || resp_id !== 2'd2 || resp_mode !== 1'b0)
      begin errors++; $display("FAIL rt_b2g: got d=%b id=%0d m=%b want 0111/2/0", resp_data, resp_id, resp_mode); end
    step();
    checks++; if (conv_count !== 16'd3) begin errors++; $display("FAIL rt_count: got %0d want 3", conv_count); end
  endtask

  task automatic test_fairness();
    logic [3:0] exp_data [4];
    exp_data[0] = 4'b0010; exp_data[1] = 4'b0100; exp_data[2] = 4'b1101; exp_data[3] = 4'b1010;
    do_reset();
    resp_ready = 1'b1; req_valid = 4'b1111; req_mode = 4'b1010; req_data = 16'hF963;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++; if (req_ready !== (4'b0001 << (k % 4)) || !$onehot(req_ready))
        begin errors++; $display("FAIL rr_grant%0d: got %b want one-hot bit %0d", k, req_ready, k % 4); end
      step();
      checks++; if (resp_id !== 2'(k % 4) || resp_data !== exp_data[k % 4] || resp_valid !== 1'b1)
        begin errors++; $display("FAIL rr_resp%0d: got id=%0d d=%b want id=%0d d=%b", k, resp_id, resp_data, k % 4, exp_data[k % 4]); end
    end
    req_valid = 4'b0000;
    step();
    checks++; if (conv_count !== 16'd8) begin errors++; $display("FAIL rr_count: got %0d want 8", conv_count); end
  endtask

  task automatic test_backpressure();
    req_valid = 4'b0001; resp_ready = 1'b0;
    step();
    req_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready%0d: got %b want 0000", k, req_ready); end
      checks++; if (resp_valid !== 1'b1 || resp_data !== 4'b0010 || resp_id !== 2'd0)
        begin errors++; $display("FAIL bp_hold%0d: got v=%b d=%b id=%0d want 1/0010/0", k, resp_valid, resp_data, resp_id); end
      step();
    end
    resp_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release: got %b want 0010", req_ready); end
    step();
    req_valid = 4'b0000;
    checks++; if (resp_valid !== 1'b1 || resp_data !== 4'b0100 || resp_id !== 2'd1)
      begin errors++; $display("FAIL bp_next: got v=%b d=%b id=%0d want 1/0100/1", resp_valid, resp_data, resp_id); end
    step();
    checks++; if (conv_count !== 16'd10) begin errors++; $display("FAIL bp_count: got %0d want 10", conv_count); end
  endtask

  task automatic test_reset_mid();
    req_valid = 4'b0001; resp_ready = 1'b0;
    step();
    req_valid = 4'b0100; resp_ready = 1'b1; rst = 1'b1;
    #1;
    checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rm_ready_in_rst: got %b want 0000", req_ready); end
    step();
    rst = 1'b0;
    checks++; if (resp_valid !== 1'b0 || conv_count !== 16'd0)
      begin errors++; $display("FAIL rm_cleared: got v=%b cnt=%0d want 0/0", resp_valid, conv_count); end
    #1;
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rm_first_grant: got %b want 0100", req_ready); end
    step();
    req_valid = 4'b0000;
    checks++; if (resp_id !== 2'd2 || resp_data !== 4'b1101)
      begin errors++; $display("FAIL rm_resp: got id=%0d d=%b want 2/1101", resp_id, resp_data); end
    step();
  endtask

  task automatic test_saturation();
    do_reset();
    resp_ready = 1'b1; req_valid = 4'b1111;
    for (int k = 1; k <= 65540; k++) begin
      step();
      if (k == 65535) begin
        checks++; if (conv_count !== 16'hFFFE) begin errors++; $display("FAIL sat_pre: got %h want FFFE", conv_count); end
      end
    end
    checks++; if (conv_count !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h want FFFF", conv_count); end
    checks++; if (resp_id !== 2'd3 || resp_data !== 4'b1010)
      begin errors++; $display("FAIL sat_conv: got id=%0d d=%b want 3/1010", resp_id, resp_data); end
    step();
    req_valid = 4'b0000;
    checks++; if (conv_count !== 16'hFFFF || resp_id !== 2'd0 || resp_data !== 4'b0010)
      begin errors++; $display("FAIL sat_after: got cnt=%h id=%0d d=%b want FFFF/0/0010", conv_count, resp_id, resp_data); end
    step();
  endtask

  initial begin
    rst = 1'b1; req_valid = 4'b0000; req_mode = 4'b0000; req_data = 16'h0000; resp_ready = 1'b0;
    step();
    test_reset();
    test_single();
    test_roundtrip();
    test_fairness();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
